// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode constants,
// ALUOp encodings and the control-word layout carried through ID/EX,
// EX/MEM and MEM/WB.
package ctrl_pkg;

    localparam int unsigned OPC_W  = 6;
    localparam int unsigned CTRL_W = 9;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_OR    = 2'b10,
        ALU_RTYPE = 2'b11
    } aluop_e;

    // Full 9-bit control word, MSB first: EX fields, then M, then WB.
    typedef struct packed {
        logic   alusrc;
        aluop_e aluop;
        logic   regdst;
        logic   branch;
        logic   memread;
        logic   memwrite;
        logic   regwrite;
        logic   memtoreg;
    } ctrl_word_t;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } exmem_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } memwb_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode -> control-word decoder.
// Ports:
//   i_op        opcode of the ID-stage instruction
//   o_ctrl_c    9-bit control word (ctrl_word_t layout), zero for j/illegal
//   o_illegal_c opcode not recognised
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned EXT_OPS = 0
) (
    input  logic [OP_W-1:0]   i_op,
    output logic [CTRL_W-1:0] o_ctrl_c,
    output logic              o_illegal_c
);

    ctrl_word_t w_ctrl;

    // Decode table; any field not set below stays 0.
    always_comb begin
        w_ctrl      = '0;
        o_illegal_c = 1'b0;
        case (i_op)
            OP_W'(OP_RTYPE): begin
                w_ctrl.aluop    = ALU_RTYPE;
                w_ctrl.regdst   = 1'b1;
                w_ctrl.regwrite = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.aluop    = ALU_ADD;
                w_ctrl.regwrite = 1'b1;
            end
            OP_W'(OP_LW): begin
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.aluop    = ALU_ADD;
                w_ctrl.memread  = 1'b1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
            end
            OP_W'(OP_SW): begin
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.aluop    = ALU_ADD;
                w_ctrl.memwrite = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                w_ctrl.aluop    = ALU_SUB;
                w_ctrl.branch   = 1'b1;
            end
            OP_W'(OP_J): begin
                w_ctrl = '0;
            end
            OP_W'(OP_ORI): begin
                if (EXT_OPS != 0) begin
                    w_ctrl.alusrc   = 1'b1;
                    w_ctrl.aluop    = ALU_OR;
                    w_ctrl.regwrite = 1'b1;
                end else begin
                    o_illegal_c = 1'b1;
                end
            end
            default: o_illegal_c = 1'b1;
        endcase
    end

    assign o_ctrl_c = w_ctrl;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID opcode, carries the control word
// through ID/EX, EX/MEM and MEM/WB, inserts bubbles on stall/flush and
// counts them with a saturating counter.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   Op_i, valid_i, stall_i, flush_i     ID-stage inputs
//   branch_o, jump_o                    combinational PC-select controls
//   ex_*_o, mem_*_o, wb_*_o             registered stage controls
//   ex_illegal_o                        EX instruction had an illegal opcode
//   bubble_cnt_o                        saturating bubble count
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned EXT_OPS = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  Op_i,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             branch_o,
    output logic             jump_o,
    output logic             ex_alusrc_o,
    output logic [1:0]       ex_aluop_o,
    output logic             ex_regdst_o,
    output logic             mem_branch_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             wb_regwrite_o,
    output logic             wb_memtoreg_o,
    output logic             ex_illegal_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic [CTRL_W-1:0] w_dec_bits;
    logic              w_dec_illegal;
    logic              w_accept;
    logic              w_bubble_req;

    ctrl_word_t        r_idex;
    logic              r_ex_illegal;
    exmem_t            r_exmem;
    memwb_t            r_memwb;
    logic [CNT_W-1:0]  r_bubble_cnt;

    ctrl_decode #(
        .OP_W    (OP_W),
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .i_op        (Op_i),
        .o_ctrl_c    (w_dec_bits),
        .o_illegal_c (w_dec_illegal)
    );

    // A stall and a flush together still cost a single bubble.
    assign w_accept     = valid_i & ~stall_i & ~flush_i;
    assign w_bubble_req = valid_i & (stall_i | flush_i);

    // PC-select is needed in ID itself, so it bypasses the pipeline and reset.
    assign branch_o = (Op_i == OP_W'(OP_BEQ)) & valid_i & ~flush_i;
    assign jump_o   = (Op_i == OP_W'(OP_J))   & valid_i & ~flush_i;

    // Stage registers advance every cycle; nothing ever holds.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_idex       <= '0;
            r_ex_illegal <= 1'b0;
            r_exmem      <= '0;
            r_memwb      <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_idex       <= w_accept ? ctrl_word_t'(w_dec_bits) : '0;
            r_ex_illegal <= w_accept & w_dec_illegal;
            r_exmem      <= '{branch:   r_idex.branch,
                              memread:  r_idex.memread,
                              memwrite: r_idex.memwrite,
                              regwrite: r_idex.regwrite,
                              memtoreg: r_idex.memtoreg};
            r_memwb      <= '{regwrite: r_exmem.regwrite,
                              memtoreg: r_exmem.memtoreg};
            if (w_bubble_req && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign ex_alusrc_o   = r_idex.alusrc;
    assign ex_aluop_o    = r_idex.aluop;
    assign ex_regdst_o   = r_idex.regdst;
    assign mem_branch_o  = r_exmem.branch;
    assign mem_read_o    = r_exmem.memread;
    assign mem_write_o   = r_exmem.memwrite;
    assign wb_regwrite_o = r_memwb.regwrite;
    assign wb_memtoreg_o = r_memwb.memtoreg;
    assign ex_illegal_o  = r_ex_illegal;
    assign bubble_cnt_o  = r_bubble_cnt;

endmodule
